// File: rtl/marfifo_burst.sv
// marfifo_burst: single-clock FIFO with registered output, occupancy count,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// flags and an autonomous burst-read engine that stalls while empty.
module marfifo_burst #(
  parameter int WIDTH   = 32,
  parameter int LENGTH  = 32,
  parameter int BURST_W = 8,
  localparam int AW     = $clog2(LENGTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   data_i,
  input  logic               valid_i,
  input  logic               read_i,
  input  logic               burst_start_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               burst_abort_i,
  input  logic [AW:0]        afull_thr_i,
  input  logic [AW:0]        aempty_thr_i,
  input  logic               clr_err_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               valid_o,
  output logic [AW:0]        locs_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               afull_o,
  output logic               aempty_o,
  output logic               overflow_o,
  output logic               underflow_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [AW:0] LOCS_FULL = (AW+1)'(LENGTH);

  logic [WIDTH-1:0]   mem_q [LENGTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        locs_q, locs_d;
  logic               empty_q, full_q, afull_q, aempty_q;
  logic [WIDTH-1:0]   data_q;
  logic               valid_q;
  logic               ovf_q, udf_q;
  logic               busy_q;
  state_t             state_q, state_d;
  logic [BURST_W-1:0] rem_q, rem_d;

  logic               write_acc_s;
  logic               burst_pop_s;
  logic               pop_req_s;
  logic               pop_acc_s;
  logic               ovf_set_s;
  logic               udf_set_s;

  // Burst engine next state, pop/write acceptance and next occupancy.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    burst_pop_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (burst_start_i && (burst_len_i != '0)) begin
          state_d = S_BURST;
          rem_d   = burst_len_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST, S_WAIT: begin
        // Abort wins over any pop in the same cycle.
        if (burst_abort_i) begin
          state_d = S_IDLE;
        end else if (!empty_q) begin
          burst_pop_s = 1'b1;
          rem_d       = rem_q - BURST_W'(1);
          state_d     = (rem_q == BURST_W'(1)) ? S_IDLE : S_BURST;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    write_acc_s = valid_i && !full_q;
    pop_req_s   = (read_i && (state_q == S_IDLE)) || burst_pop_s;
    pop_acc_s   = pop_req_s && !empty_q;
    // Overflow is flagged on a write at full even if a pop frees a slot now.
    ovf_set_s   = valid_i && full_q;
    // Only explicit reads can underflow; burst stalls are silent.
    udf_set_s   = read_i && (state_q == S_IDLE) && empty_q;
    locs_d      = locs_q + (AW+1)'(write_acc_s) - (AW+1)'(pop_acc_s);
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (write_acc_s) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Pointers, occupancy, flags, output word, errors and burst state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      locs_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      busy_q   <= 1'b0;
      state_q  <= S_IDLE;
      rem_q    <= '0;
    end else begin
      if (write_acc_s) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop_acc_s) begin
        rptr_q <= rptr_q + AW'(1);
        data_q <= mem_q[rptr_q];
      end
      valid_q  <= pop_acc_s;
      locs_q   <= locs_d;
      empty_q  <= (locs_d == '0);
      full_q   <= (locs_d == LOCS_FULL);
      afull_q  <= (locs_d >= afull_thr_i);
      aempty_q <= (locs_d <= aempty_thr_i);
      // A set in the same cycle as a clear keeps the flag set.
      ovf_q    <= ovf_set_s || (ovf_q && !clr_err_i);
      udf_q    <= udf_set_s || (udf_q && !clr_err_i);
      state_q  <= state_d;
      rem_q    <= rem_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign locs_o      = locs_q;
  assign empty_o     = empty_q;
  assign full_o      = full_q;
  assign afull_o     = afull_q;
  assign aempty_o    = aempty_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;
  assign busy_o      = busy_q;

endmodule
